uart_itcm_loader: RTL and testbench

UART_ITCM_LOADER -- requirements
Module: uart_itcm_loader

---
 rtl/uart_itcm_loader.sv | 204 ++++++++++++++++++++
 tb/tb_uart_itcm_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_itcm_loader.sv
// UART boot loader: receives an A5/LEN/data/checksum frame over 8N1 UART and writes it to ITCM.
// Define LOADER_CHKSUM_EN to verify the checksum byte; otherwise it is received and ignored.
`ifndef ITCM_ADDR_WIDTH
`define ITCM_ADDR_WIDTH 16
`endif

module uart_itcm_loader #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int ITCM_ADDR_WIDTH = `ITCM_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       uart_debug_pin,
  input  logic                       uart_rx_i,
  output logic                       itcm_we_o,
  output logic [ITCM_ADDR_WIDTH-3:0] itcm_waddr_o,
  output logic [31:0]                itcm_wdata_o,
  output logic                       cpu_hold_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int WW = ITCM_ADDR_WIDTH - 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]   DEPTH   = 17'd1 << WW;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, HDR, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  // ---------------- receiver ----------------
  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     rx_state, rx_state_d;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_shift;
  logic          half_hit, bit_hit, byte_stb, frame_err;

  assign half_hit = (clk_cnt == HALF_M1);
  assign bit_hit  = (clk_cnt == BIT_M1);

  always_comb begin
    rx_state_d = rx_state;
    byte_stb   = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_d = RX_START;
      RX_START: if (half_hit) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && bit_cnt == 3'd7) rx_state_d = RX_STOP;
      RX_STOP: begin
        if (bit_hit) begin
          rx_state_d = RX_IDLE;
          byte_stb   = rx_sync;
          frame_err  = !rx_sync;
        end
      end
      default:  rx_state_d = RX_IDLE;
    endcase
    if (!uart_debug_pin) rx_state_d = RX_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= uart_rx_i;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_d;
      // Counter restarts at the start re-check so data bits land mid-bit.
      if (rx_state == RX_IDLE || (rx_state == RX_START && half_hit) || bit_hit)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == RX_IDLE)
        bit_cnt <= '0;
      else if (rx_state == RX_DATA && bit_hit) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_cnt  <= bit_cnt + 1'b1;
      end
    end
  end

  // ---------------- frame decoder ----------------
  state_t      state_q, state_d;
  logic        we_d;
  logic [15:0] len_q, wcnt_q;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [16:0] len_full;
`ifdef LOADER_CHKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign len_full = {1'b0, rx_shift, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    if (!uart_debug_pin) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = HDR;
        HDR: begin
          if (frame_err) state_d = ERR;
          else if (byte_stb && rx_shift == 8'hA5) state_d = LEN0;
        end
        LEN0: begin
          if (frame_err) state_d = ERR;
          else if (byte_stb) state_d = LEN1;
        end
        LEN1: begin
          if (frame_err) state_d = ERR;
          else if (byte_stb) begin
            if (len_full > DEPTH)       state_d = ERR;
            else if (len_full == 17'd0) state_d = CSUM;
            else                        state_d = DATA;
          end
        end
        DATA: begin
          if (frame_err) state_d = ERR;
          else if (byte_stb && byte_cnt == 2'd3) begin
            we_d = 1'b1;
            if (wcnt_q == len_q - 16'd1) state_d = CSUM;
          end
        end
        CSUM: begin
          if (frame_err) state_d = ERR;
          else if (byte_stb) begin
`ifdef LOADER_CHKSUM_EN
            state_d = (csum_q == rx_shift) ? DONE : ERR;
`else
            state_d = DONE;
`endif
          end
        end
        DONE:    state_d = DONE;
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      itcm_we_o    <= 1'b0;
      itcm_waddr_o <= '0;
      itcm_wdata_o <= '0;
      len_q        <= '0;
      wcnt_q       <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
`ifdef LOADER_CHKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      itcm_we_o <= we_d;
      if (we_d) begin
        itcm_waddr_o <= wcnt_q[WW-1:0];
        itcm_wdata_o <= {rx_shift, word_buf};
      end
      // Frame context is rebuilt from scratch every time the decoder waits for a header.
      if (state_q == HDR || state_d == IDLE) begin
        len_q    <= '0;
        wcnt_q   <= '0;
        byte_cnt <= '0;
        word_buf <= '0;
`ifdef LOADER_CHKSUM_EN
        csum_q   <= '0;
`endif
      end else if (byte_stb) begin
        unique case (state_q)
          LEN0: len_q <= {8'h00, rx_shift};
          LEN1: len_q[15:8] <= rx_shift;
          DATA: begin
            word_buf <= {rx_shift, word_buf[23:8]};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) wcnt_q <= wcnt_q + 16'd1;
`ifdef LOADER_CHKSUM_EN
            csum_q <= csum_q + rx_shift;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_hold_o = (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CSUM);
  assign done_o     = (state_q == DONE);
  assign err_o      = (state_q == ERR);

endmodule

// File: tb/tb_uart_itcm_loader.sv
// Bench for uart_itcm_loader: directed frame table, randomized frames checked against a frame-level model.
module tb_uart_itcm_loader;

  localparam int CPB   = 16;
  localparam int AW    = 6;
  localparam int WW    = AW - 2;
  localparam int DEPTH = 1 << WW;
`ifdef LOADER_CHKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_debug_pin = 1'b0;
  logic          uart_rx_i = 1'b1;
  logic          itcm_we_o;
  logic [WW-1:0] itcm_waddr_o;
  logic [31:0]   itcm_wdata_o;
  logic          cpu_hold_o, done_o, err_o;

  uart_itcm_loader #(.CLKS_PER_BIT(CPB), .ITCM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .uart_debug_pin(uart_debug_pin), .uart_rx_i(uart_rx_i),
    .itcm_we_o(itcm_we_o), .itcm_waddr_o(itcm_waddr_o), .itcm_wdata_o(itcm_wdata_o),
    .cpu_hold_o(cpu_hold_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [WW+31:0] cap[$];
  logic [WW+31:0] exp_w[$];
  bit m_done, m_err, m_hold;
  logic we_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Write monitor: every strobe is logged and must be a single-cycle pulse.
  always @(posedge clk) begin
    #1;
    if (itcm_we_o) begin
      cap.push_back({itcm_waddr_o, itcm_wdata_o});
      check("we_single_cycle", {63'd0, we_prev}, 64'd0);
    end
    we_prev = itcm_we_o;
  end

  // Frame-level reference: locate the header, then walk LEN words and the checksum.
  function automatic void model(input bq_t q, input int bad_in);
    int n, h, len, base, c, bad;
    logic [7:0] sum;
    exp_w.delete();
    m_done = 1'b0; m_err = 1'b0; m_hold = 1'b0;
    n = q.size();
    bad = (bad_in < 0) ? 32'h7fff_ffff : bad_in;
    h = -1;
    for (int i = 0; i < n; i++) begin
      if (i == bad) begin m_err = 1'b1; return; end
      if (q[i] == 8'hA5) begin h = i; break; end
    end
    if (h < 0) return;
    if (bad <= h + 2) begin m_err = 1'b1; return; end
    if (h + 2 >= n) begin m_hold = 1'b1; return; end
    len = int'({q[h+2], q[h+1]});
    if (len > DEPTH) begin m_err = 1'b1; return; end
    sum = 8'd0;
    for (int w = 0; w < len; w++) begin
      base = h + 3 + 4 * w;
      if (bad < base + 4) begin m_err = 1'b1; return; end
      if (base + 3 >= n) begin m_hold = 1'b1; return; end
      exp_w.push_back({WW'(w), q[base+3], q[base+2], q[base+1], q[base]});
      sum = 8'(sum + q[base] + q[base+1] + q[base+2] + q[base+3]);
    end
    c = h + 3 + 4 * len;
    if (bad <= c) begin m_err = 1'b1; return; end
    if (c >= n) begin m_hold = 1'b1; return; end
    if (CK && sum != q[c]) m_err = 1'b1;
    else m_done = 1'b1;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx_i = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input bq_t q, input int bad, input string tag);
    uart_debug_pin = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_idle_flags"}, {61'd0, done_o, err_o, cpu_hold_o}, 64'd0);
    uart_debug_pin = 1'b1;
    repeat (4) @(negedge clk);
    cap.delete();
    model(q, bad);
    for (int i = 0; i < q.size(); i++) begin
      if (i == bad) begin send_byte(q[i], 1'b0); break; end
      send_byte(q[i], 1'b1);
    end
    repeat (2 * CPB) @(negedge clk);
    check({tag, "_done"}, {63'd0, done_o}, {63'd0, m_done});
    check({tag, "_err"}, {63'd0, err_o}, {63'd0, m_err});
    check({tag, "_hold"}, {63'd0, cpu_hold_o}, {63'd0, m_hold});
    check({tag, "_nwrites"}, 64'(cap.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      check({tag, "_write"}, (i < cap.size()) ? 64'(cap[i]) : '1, 64'(exp_w[i]));
  endtask

  typedef struct {
    int           n;
    logic [127:0] b;
    int           bad;
    bit           x_done;
    bit           x_err;
    int           x_nw;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    bq_t q;
    int len, bad;
    logic [7:0] sum, g;

    tbl[0] = '{12, {96'hA50200130000006F00000082, 32'h0}, -1, 1'b1, 1'b0, 2};
    tbl[1] = '{12, {96'hA50200130000006F00000083, 32'h0}, -1, !CK, CK, 2};
    tbl[2] = '{6,  {48'h00FFA5000000, 80'h0}, -1, 1'b1, 1'b0, 0};
    tbl[3] = '{8,  {64'hA501001122334455, 64'h0}, 5, 1'b0, 1'b1, 0};
    tbl[4] = '{3,  {24'hA51100, 104'h0}, -1, 1'b0, 1'b1, 0};

    repeat (3) @(negedge clk);
    check("rst_we", {63'd0, itcm_we_o}, 64'd0);
    check("rst_waddr", 64'(itcm_waddr_o), 64'd0);
    check("rst_wdata", 64'(itcm_wdata_o), 64'd0);
    check("rst_flags", {61'd0, cpu_hold_o, done_o, err_o}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      q.delete();
      for (int i = 0; i < tbl[k].n; i++) q.push_back(tbl[k].b[127-8*i -: 8]);
      run_frame(q, tbl[k].bad, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_tbl_done", k), {63'd0, done_o}, {63'd0, tbl[k].x_done});
      check($sformatf("vec%0d_tbl_err", k), {63'd0, err_o}, {63'd0, tbl[k].x_err});
      check($sformatf("vec%0d_tbl_nw", k), 64'(cap.size()), 64'(tbl[k].x_nw));
      if (k == 0) begin
        check("vec0_word0", (cap.size() > 0) ? 64'(cap[0]) : '1, 64'({4'd0, 32'h0000_0013}));
        check("vec0_word1", (cap.size() > 1) ? 64'(cap[1]) : '1, 64'({4'd1, 32'h0000_006F}));
      end
      if (k == 3) begin
        uart_debug_pin = 1'b0;
        @(posedge clk); #1;
        check("abort_next_cycle", {61'd0, done_o, err_o, cpu_hold_o}, 64'd0);
        @(negedge clk);
      end
    end

    // Reset in the middle of the second data word.
    uart_debug_pin = 1'b0;
    repeat (3) @(negedge clk);
    uart_debug_pin = 1'b1;
    repeat (4) @(negedge clk);
    cap.delete();
    q = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    foreach (q[i]) send_byte(q[i], 1'b1);
    uart_rx_i = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("pre_rst_hold", {63'd0, cpu_hold_o}, 64'd1);
    check("pre_rst_writes", 64'(cap.size()), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", {itcm_we_o, itcm_waddr_o, itcm_wdata_o, cpu_hold_o, done_o, err_o},
          '0);
    @(negedge clk);
    rst = 1'b0;
    uart_rx_i = 1'b1;
    repeat (4) @(negedge clk);

    // Randomized frames; the first fills the whole ITCM.
    for (int it = 0; it < 12; it++) begin
      q.delete();
      if (it != 0) begin
        for (int p = $urandom_range(0, 2); p > 0; p--) begin
          g = 8'($urandom);
          if (g == 8'hA5) g = 8'h5A;
          q.push_back(g);
        end
      end
      if (it == 0) len = DEPTH;
      else if ($urandom_range(0, 4) == 0) len = DEPTH + 1;
      else len = $urandom_range(0, 6);
      q.push_back(8'hA5);
      q.push_back(8'(len));
      q.push_back(8'(len >> 8));
      if (len <= DEPTH) begin
        sum = 8'd0;
        for (int i = 0; i < 4 * len; i++) begin
          g = 8'($urandom);
          sum = 8'(sum + g);
          q.push_back(g);
        end
        q.push_back(($urandom_range(0, 1) == 0) ? sum : 8'($urandom));
      end
      bad = (it != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, q.size() - 1) : -1;
      run_frame(q, bad, $sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
